latency_match_pipe: RTL
=======================

Name: latency_match_pipe

Overview:
- Parametrised latency-matching delay line for valid and sideband tags, run alongside a pipelined fixed-point arithmetic unit such as rootsqr, mul or div.
- Successor to the fixed-delay valid matcher. It adds a clock enable for stalling the arithmetic pipe and a synchronous flush.
- It also carries a tag with each valid, reports in-flight occupancy and flags an empty pipeline.
- DELAY is set at instantiation to the companion unit's latency constant, so results and their tags leave together.

Parameters:
- WIDTH, 1: tag width in bits carried with each valid; 1 or more.
- DELAY, 4: pipeline depth in enabled cycles; 0 or more. 0 means combinational pass-through.
- CW, $clog2(DELAY+1) (minimum 1): width of the occupancy count; derived, not overridden.

Ports:
- clk  input  1  clock, shared with the companion arithmetic unit
- reset  input  1  asynchronous reset, active-high
- ce  input  1  clock enable; 1 advances the pipe one stage, 0 holds all state
- flush  input  1  synchronous clear of all in-flight entries
- i_valid  input  1  input entry valid
- i_tag  input  WIDTH  tag accompanying i_valid
- o_valid  output  1  delayed valid
- o_tag  output  WIDTH  delayed tag; forced to 0 when o_valid=0
- inflight  output  CW  number of valid entries currently held in stages 1..DELAY
- empty  output  1  1 when inflight==0

Behaviour:
- Reset, asynchronous, active-high:
  - All stage valid bits 0; all stage tags 0; inflight=0.
  - Outputs during and after reset: o_valid=0, o_tag=0, empty=1.
  - Asserting reset mid-operation discards in-flight entries immediately; nothing emerges afterwards.
- Structure, DELAY>0:
  - Stages 1..DELAY, each holding {v, tag}.
  - o_valid=v[DELAY]; o_tag = v[DELAY] ? tag[DELAY] : 0.
  - All outputs are registered; there is no combinational path from input to output.
- ce=1 and flush=0, rising edge:
  - v[1]<=i_valid; v[k]<=v[k-1] for k>1.
  - tag[1]<=i_tag when i_valid=1, else tag[1]<=0. Tags shift with their valids.
  - Latency is exactly DELAY enabled cycles: an entry accepted at enabled edge n appears on o_valid after enabled edge n+DELAY-1, i.e. visible for the cycle following the DELAY-th enabled edge counting acceptance as edge 1.
- ce=0 and flush=0:
  - All stages hold; inflight holds.
  - i_valid is ignored and not accepted. The upstream must present inputs only with ce=1, exactly like the companion unit.
  - o_valid/o_tag stay stable for the whole stall, so an output entry is visible for every stalled cycle. The consumer qualifies it with ce.
- flush=1, rising edge:
  - All v<=0, tags<=0, inflight<=0, regardless of ce.
  - An i_valid in the same cycle is dropped; flush wins.
  - o_valid is 0 from the next cycle.
- inflight counter:
  - On each enabled, non-flush edge: next = inflight + (i_valid) - (v[DELAY]).
  - Simultaneous accept and exit leaves the count unchanged.
  - Never exceeds DELAY and never underflows. This is asserted in simulation.
- DELAY=0:
  - o_valid=i_valid, o_tag = i_valid ? i_tag : 0, combinational.
  - ce and flush have no effect.
  - inflight is 0 constantly; empty is 1 constantly.
- Back-to-back:
  - Full throughput: one entry per enabled cycle; DELAY entries may be in flight simultaneously.

Test Plan:
- Reset then single entry, DELAY=4, WIDTH=8, ce=1: i_valid=1 with i_tag=8'hA5 for one cycle -> o_valid=1 with o_tag=8'hA5 exactly 4 cycles later for one cycle. inflight goes 1,1,1,1 then 0; empty is 0 while in flight.
- Full stream, DELAY=4: tags 1..10 on consecutive cycles -> outputs 1..10 on consecutive cycles starting at cycle 4. inflight saturates at 4, never reads 5, and returns to 0; o_tag=0 whenever o_valid=0.
- Stall: tag 8'h3C accepted, then ce=0 for 3 cycles after the 2nd enabled edge -> o_valid asserts after 4 enabled edges (7 clocks total). The counter holds at 1 during the stall; an i_valid asserted during the stall is not delivered.
- Flush with simultaneous input: 3 entries in flight, then flush=1 together with i_valid=1 (tag 8'h77) -> no output ever emerges; inflight=0 and empty=1 the cycle after flush.
- Async reset mid-operation: 2 entries in flight, reset pulsed between clock edges -> o_valid=0, o_tag=0 and inflight=0 immediately, with no output after release.
- DELAY=0 build: i_valid=1 with i_tag=1 -> o_valid=1 and o_tag=1 in the same cycle; empty stays 1 throughout.

Source files
------------

// File: rtl/latency_match_pipe.sv
// latency_match_pipe: delays a valid bit and its sideband tag by DELAY enabled
// cycles so they leave together with the result of a companion arithmetic
// pipeline. Supports stall (ce), synchronous flush, occupancy count and empty.
module latency_match_pipe #(
   parameter int WIDTH = 1,
   parameter int DELAY = 4,
   parameter int CW    = (DELAY == 0) ? 1 : $clog2(DELAY + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             flush,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_tag,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_tag,
   output logic [CW-1:0]    inflight,
   output logic             empty
);

   generate
      if (DELAY == 0) begin : g_pass
         // Zero latency: the companion unit is combinational, so just pass
         // through; clock, reset, ce and flush have nothing to act on.
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, reset, ce, flush};

         // Combinational pass-through with the tag masked by valid
         always_comb begin
            o_valid  = i_valid;
            o_tag    = i_valid ? i_tag : '0;
            inflight = '0;
            empty    = 1'b1;
         end
      end else begin : g_pipe
         logic             v  [1:DELAY];
         logic [WIDTH-1:0] tg [1:DELAY];
         logic [CW-1:0]    cnt;

         // Stage shift register: reset/flush clear, ce advances, otherwise hold
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int unsigned k = 1; k <= DELAY; k++) begin
                  v[k]  <= 1'b0;
                  tg[k] <= '0;
               end
            end else if (flush) begin
               for (int unsigned k = 1; k <= DELAY; k++) begin
                  v[k]  <= 1'b0;
                  tg[k] <= '0;
               end
            end else if (ce) begin
               v[1]  <= i_valid;
               tg[1] <= i_valid ? i_tag : '0;
               for (int unsigned k = 2; k <= DELAY; k++) begin
                  v[k]  <= v[k-1];
                  tg[k] <= tg[k-1];
               end
            end
         end

         // Occupancy: +1 on accept, -1 on exit from the last stage
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt <= '0;
            end else if (flush) begin
               cnt <= '0;
            end else if (ce) begin
               cnt <= cnt + CW'(i_valid) - CW'(v[DELAY]);
            end
         end

         // Occupancy can never exceed the number of stages
         always_ff @(posedge clk) begin
            if (!reset) begin
               assert (cnt <= CW'(DELAY))
                  else $error("inflight %0d exceeds DELAY %0d", cnt, DELAY);
            end
         end

         // Outputs driven straight from registers; tags are zero when invalid
         always_comb begin
            o_valid  = v[DELAY];
            o_tag    = v[DELAY] ? tg[DELAY] : '0;
            inflight = cnt;
            empty    = (cnt == '0);
         end
      end
   endgenerate

endmodule
